// File: rtl/exe_pkg.sv
// Shared execute-side types: ALU opcode encoding, the buffered ID/EX entry, and the WB snoop helper.
package exe_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_AW_DEF = 5;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD    = 4'b0000;
  localparam alu_op_t ALU_SUB    = 4'b1000;
  localparam alu_op_t ALU_SLL    = 4'b0001;
  localparam alu_op_t ALU_SLT    = 4'b0010;
  localparam alu_op_t ALU_SLTU   = 4'b0011;
  localparam alu_op_t ALU_XOR    = 4'b0100;
  localparam alu_op_t ALU_SRL    = 4'b0101;
  localparam alu_op_t ALU_SRA    = 4'b1101;
  localparam alu_op_t ALU_OR     = 4'b0110;
  localparam alu_op_t ALU_AND    = 4'b0111;
  localparam alu_op_t ALU_MUL    = 4'b1010;
  localparam alu_op_t ALU_MULH   = 4'b1011;
  localparam alu_op_t ALU_MULHSU = 4'b1100;

  typedef struct packed {
    logic [DATA_W-1:0]     pc;
    logic [REG_AW_DEF-1:0] rs1_addr;
    logic [REG_AW_DEF-1:0] rs2_addr;
    logic [DATA_W-1:0]     rs1_data;
    logic [DATA_W-1:0]     rs2_data;
    logic [REG_AW_DEF-1:0] rd_addr;
    logic [DATA_W-1:0]     imm;
    alu_op_t               alu_op;
    logic                  use_imm;
    logic                  use_pc;
    logic                  reg_write;
  } id_ex_entry_t;

  // Refresh stored register data with a write-back to the same source index (never x0).
  function automatic id_ex_entry_t wb_snoop(id_ex_entry_t e, logic en,
                                            logic [REG_AW_DEF-1:0] rd,
                                            logic [DATA_W-1:0] data);
    id_ex_entry_t r;
    r = e;
    if (en && rd != '0) begin
      if (rd == e.rs1_addr) r.rs1_data = data;
      if (rd == e.rs2_addr) r.rs2_data = data;
    end
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side and execute-side handshake bundle of the ID/EX stage.
interface id_ex_stage_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_pc;
  logic [REG_AW-1:0] in_rs1_addr;
  logic [REG_AW-1:0] in_rs2_addr;
  logic [WIDTH-1:0]  in_rs1_data;
  logic [WIDTH-1:0]  in_rs2_data;
  logic [REG_AW-1:0] in_rd_addr;
  logic [WIDTH-1:0]  in_imm;
  logic [3:0]        in_alu_op;
  logic              in_use_imm;
  logic              in_use_pc;
  logic              in_reg_write;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_inA;
  logic [WIDTH-1:0]  out_inB;
  logic [3:0]        out_alu_op;
  logic [WIDTH-1:0]  out_rs2_val;
  logic [WIDTH-1:0]  out_pc;
  logic [REG_AW-1:0] out_rd_addr;
  logic              out_reg_write;

  modport master (
    output in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data, in_rd_addr,
           in_imm, in_alu_op, in_use_imm, in_use_pc, in_reg_write, out_ready,
    input  in_ready, out_valid, out_inA, out_inB, out_alu_op, out_rs2_val, out_pc, out_rd_addr,
           out_reg_write
  );

  modport slave (
    input  in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data, in_rd_addr,
           in_imm, in_alu_op, in_use_imm, in_use_pc, in_reg_write, out_ready,
    output in_ready, out_valid, out_inA, out_inB, out_alu_op, out_rs2_val, out_pc, out_rd_addr,
           out_reg_write
  );
endinterface

// File: rtl/fwd_mux.sv
// Per-operand bypass select: MEM result over WB result over stored data; x0 never forwards.
module fwd_mux #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [WIDTH-1:0]  stored,
  input  logic              mem_en,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  output logic [WIDTH-1:0]  result
);

  always_comb begin
    result = stored;
    if (rs_addr != '0) begin
      if (mem_en && mem_rd == rs_addr) begin
        result = mem_data;
      end else if (wb_en && wb_rd == rs_addr) begin
        result = wb_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: 2-entry skid buffer (slot0 = head, slot1 = skid) with WB snoop on stored
// operands and MEM/WB forwarding on the head before ALU operand selection.
module id_ex_stage
  import exe_pkg::*;
#(
  // Must match the package entry widths (DATA_W / REG_AW_DEF).
  parameter int unsigned WIDTH  = DATA_W,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  id_ex_stage_if.slave      bus,
  input  logic              mem_fwd_en,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [WIDTH-1:0]  mem_fwd_data,
  input  logic              wb_fwd_en,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [WIDTH-1:0]  wb_fwd_data
);

  id_ex_entry_t slot0_q, slot0_d, slot1_q, slot1_d;
  id_ex_entry_t in_entry, slot0_snp, slot1_snp, in_snp;
  logic         valid0_q, valid0_d, valid1_q, valid1_d;
  logic         accept, pop;
  logic [WIDTH-1:0] fwd_rs1, fwd_rs2;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = valid0_q & bus.out_ready;

  always_comb begin
    in_entry = '{
      pc:        bus.in_pc,
      rs1_addr:  bus.in_rs1_addr,
      rs2_addr:  bus.in_rs2_addr,
      rs1_data:  bus.in_rs1_data,
      rs2_data:  bus.in_rs2_data,
      rd_addr:   bus.in_rd_addr,
      imm:       bus.in_imm,
      alu_op:    bus.in_alu_op,
      use_imm:   bus.in_use_imm,
      use_pc:    bus.in_use_pc,
      reg_write: bus.in_reg_write
    };
    in_snp    = wb_snoop(in_entry, wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    slot0_snp = valid0_q ? wb_snoop(slot0_q, wb_fwd_en, wb_fwd_rd, wb_fwd_data) : slot0_q;
    slot1_snp = valid1_q ? wb_snoop(slot1_q, wb_fwd_en, wb_fwd_rd, wb_fwd_data) : slot1_q;
  end

  always_comb begin
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    slot0_d  = slot0_snp;
    slot1_d  = slot1_snp;
    if (flush) begin
      // Data is kept so outputs hold their last value; only the valids drop.
      valid0_d = 1'b0;
      valid1_d = 1'b0;
    end else if (pop) begin
      if (valid1_q) begin
        slot0_d  = slot1_snp;
        valid1_d = 1'b0;
      end else if (accept) begin
        slot0_d = in_snp;
      end else begin
        valid0_d = 1'b0;
      end
    end else if (accept) begin
      if (!valid0_q) begin
        slot0_d  = in_snp;
        valid0_d = 1'b1;
      end else begin
        slot1_d  = in_snp;
        valid1_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      slot0_q  <= '0;
      slot1_q  <= '0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
    end
  end

  fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr  (slot0_q.rs1_addr),
    .stored   (slot0_q.rs1_data),
    .mem_en   (mem_fwd_en),
    .mem_rd   (mem_fwd_rd),
    .mem_data (mem_fwd_data),
    .wb_en    (wb_fwd_en),
    .wb_rd    (wb_fwd_rd),
    .wb_data  (wb_fwd_data),
    .result   (fwd_rs1)
  );

  fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr  (slot0_q.rs2_addr),
    .stored   (slot0_q.rs2_data),
    .mem_en   (mem_fwd_en),
    .mem_rd   (mem_fwd_rd),
    .mem_data (mem_fwd_data),
    .wb_en    (wb_fwd_en),
    .wb_rd    (wb_fwd_rd),
    .wb_data  (wb_fwd_data),
    .result   (fwd_rs2)
  );

  // in_ready comes straight from a flop so it never depends on out_ready.
  assign bus.in_ready      = ~valid1_q;
  assign bus.out_valid     = valid0_q;
  assign bus.out_inA       = slot0_q.use_pc ? slot0_q.pc : fwd_rs1;
  assign bus.out_inB       = slot0_q.use_imm ? slot0_q.imm : fwd_rs2;
  assign bus.out_rs2_val   = fwd_rs2;
  assign bus.out_alu_op    = slot0_q.alu_op;
  assign bus.out_pc        = slot0_q.pc;
  assign bus.out_rd_addr   = slot0_q.rd_addr;
  assign bus.out_reg_write = slot0_q.reg_write;

endmodule
